// File: rtl/booth_wallace_mul_pipe_if.sv
// Operand/result bundle for booth_wallace_mul_pipe: request side, response side and flush.
interface booth_wallace_mul_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_a;
    logic [XLEN-1:0]     in_b;
    logic [1:0]          in_sign;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [2*XLEN-1:0]   out_result;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output flush, in_valid, in_a, in_b, in_sign, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, in_sign, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/booth_wallace_mul_pipe.sv
// Pipelined radix-4 Booth multiplier: Booth partial products reduced by a 3:2 Wallace tree,
// registered as sum/carry, then a carry-propagate add into the output register.
module booth_wallace_mul_pipe #(
    parameter int XLEN   = 64,
    parameter int TAG_W  = 5,
    parameter int IN_REG = 0
) (
    input logic                      clk,
    input logic                      rst,
    booth_wallace_mul_pipe_if.slave  bus
);
    localparam int W   = 2 * XLEN;
    localparam int NPP = XLEN / 2 + 1;
    localparam int L   = XLEN + 3;
    localparam int N0  = NPP + 2;

    function automatic int rows_at(input int lvl);
        int n = N0;
        for (int k = 0; k < lvl; k++) n = (n / 3) * 2 + n % 3;
        return n;
    endfunction

    function automatic int num_levels();
        int n = N0;
        int lv = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + n % 3;
            lv++;
        end
        return lv;
    endfunction

    // Each row stores its sign bit inverted (adds 2^(L-1) per row); this constant takes it all back.
    function automatic logic [W-1:0] const_row();
        logic [W-1:0] c = '0;
        for (int i = 0; i < NPP; i++) c = c - ({{(W-1){1'b0}}, 1'b1} << (L - 1 + 2 * i));
        return c;
    endfunction

    localparam int           LEVELS    = num_levels();
    localparam logic [W-1:0] CONST_ROW = const_row();

    // Handshake: a stage register loads when it is empty or its downstream stage advances.
    // in_ready depends only on stage valids, out_ready and flush, never on in_valid.
    logic             s1_adv, s2_adv;
    logic             s1_valid, out_valid_q;
    logic [W-1:0]     s1_sum, s1_carry, out_result_q;
    logic [TAG_W-1:0] s1_tag, out_tag_q;

    logic             f_valid;
    logic [XLEN-1:0]  f_a, f_b;
    logic [1:0]       f_sign;
    logic [TAG_W-1:0] f_tag;

    assign s2_adv = !out_valid_q | bus.out_ready;
    assign s1_adv = !s1_valid | s2_adv;

    if (IN_REG != 0) begin : g_in_reg
        logic             s0_valid;
        logic             s0_adv;
        logic [XLEN-1:0]  s0_a, s0_b;
        logic [1:0]       s0_sign;
        logic [TAG_W-1:0] s0_tag;

        assign s0_adv       = !s0_valid | s1_adv;
        assign bus.in_ready = s0_adv & ~bus.flush;

        always_ff @(posedge clk) begin
            if (rst || bus.flush) s0_valid <= 1'b0;
            else if (s0_adv)      s0_valid <= bus.in_valid;
        end

        always_ff @(posedge clk) begin
            if (s0_adv && bus.in_valid) begin
                s0_a    <= bus.in_a;
                s0_b    <= bus.in_b;
                s0_sign <= bus.in_sign;
                s0_tag  <= bus.in_tag;
            end
        end

        assign f_valid = s0_valid;
        assign f_a     = s0_a;
        assign f_b     = s0_b;
        assign f_sign  = s0_sign;
        assign f_tag   = s0_tag;
    end else begin : g_no_reg
        assign bus.in_ready = s1_adv & ~bus.flush;
        assign f_valid      = bus.in_valid & ~bus.flush;
        assign f_a          = bus.in_a;
        assign f_b          = bus.in_b;
        assign f_sign       = bus.in_sign;
        assign f_tag        = bus.in_tag;
    end

    // Sign code 01 degrades to unsigned*unsigned, so b is signed only for 11.
    logic            a_signed, b_signed;
    logic [XLEN+1:0] a_ext, b_ext;
    logic [XLEN+2:0] b_pad;
    logic [L-1:0]    a_l;

    assign a_signed = f_sign[1];
    assign b_signed = f_sign[1] & f_sign[0];
    assign a_ext    = {{2{a_signed & f_a[XLEN-1]}}, f_a};
    assign b_ext    = {{2{b_signed & f_b[XLEN-1]}}, f_b};
    assign b_pad    = {b_ext, 1'b0};
    assign a_l      = {a_ext[XLEN+1], a_ext};

    logic [W-1:0]   pp_row [NPP];
    logic [NPP-1:0] neg_bits;
    logic [W-1:0]   neg_row;

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        logic [2:0]   trip;
        logic         one, two, neg;
        logic [L-1:0] mag, pp;

        assign trip = b_pad[2*i+2 -: 3];
        assign one  = trip[0] ^ trip[1];
        assign two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
        assign neg  = trip[2] & ~(trip[1] & trip[0]);
        assign mag  = one ? a_l : (two ? {a_l[L-2:0], 1'b0} : '0);
        assign pp   = mag ^ {L{neg}};
        assign pp_row[i]   = {{(W-L){1'b0}}, ~pp[L-1], pp[L-2:0]} << (2 * i);
        assign neg_bits[i] = neg;
    end

    always_comb begin
        neg_row = '0;
        for (int i = 0; i < NPP; i++) neg_row[2*i] = neg_bits[i];
    end

    // Level 0 holds the raw rows; every further level applies 3:2 cells to row triples.
    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
        localparam int N = rows_at(lv);
        logic [W-1:0] r [N];

        if (lv == 0) begin : g_init
            for (genvar i = 0; i < NPP; i++) begin : g_load
                assign r[i] = pp_row[i];
            end
            assign r[NPP]     = neg_row;
            assign r[NPP + 1] = CONST_ROW;
        end else begin : g_red
            localparam int NP = rows_at(lv - 1);
            for (genvar j = 0; j < NP / 3; j++) begin : g_csa
                logic [W-1:0] x, y, z;
                assign x          = g_lvl[lv-1].r[3*j];
                assign y          = g_lvl[lv-1].r[3*j+1];
                assign z          = g_lvl[lv-1].r[3*j+2];
                assign r[2*j]     = x ^ y ^ z;
                assign r[2*j + 1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
            for (genvar j = 0; j < NP % 3; j++) begin : g_pass
                assign r[2*(NP/3) + j] = g_lvl[lv-1].r[3*(NP/3) + j];
            end
        end
    end

    logic [W-1:0] tree_sum, tree_carry;
    assign tree_sum   = g_lvl[LEVELS].r[0];
    assign tree_carry = g_lvl[LEVELS].r[1];

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (s1_adv) s1_valid    <= f_valid;
            if (s2_adv) out_valid_q <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && f_valid) begin
            s1_sum   <= tree_sum;
            s1_carry <= tree_carry;
            s1_tag   <= f_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (s2_adv && s1_valid) begin
            out_result_q <= s1_sum + s1_carry;
            out_tag_q    <= s1_tag;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
endmodule
